// File: rtl/uart_mmio_pkg.sv
// Shared constants and types for the memory-mapped UART controller.
package uart_mmio_pkg;

  // Register offsets, addressed by addr[3:2] inside the 16-byte window.
  localparam logic [1:0] OFF_TX   = 2'd0;
  localparam logic [1:0] OFF_RX   = 2'd1;
  localparam logic [1:0] OFF_STAT = 2'd2;
  localparam logic [1:0] OFF_RSVD = 2'd3;

  // STATUS register bit positions.
  localparam int ST_TXFULL  = 0;
  localparam int ST_TXEMPTY = 1;
  localparam int ST_RXNE    = 2;
  localparam int ST_TXOVF   = 3;
  localparam int ST_RXOVR   = 4;

  // Store strobe encodings coming from the core.
  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_SB   = 2'b01,
    MW_SH   = 2'b10,
    MW_SW   = 2'b11
  } mem_write_e;

  // Transmit drain state machine.
  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } drain_state_e;

  // Cycles to wait for tx_busy to rise before assuming the byte went out.
  localparam int BUSY_TIMEOUT = 4;

  // Any non-zero store strobe counts as a write, whatever its width.
  function automatic logic is_store(input logic [1:0] mw);
    return mw != MW_NONE;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a pop on empty is ignored and a
// push on full is accepted only when a same-cycle pop frees the slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign head    = mem[rptr[AW-1:0]];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer update; both pointers wrap naturally through the extra MSB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage write.
  // NOTE: the data array is deliberately not reset; the pointers alone define
  // which entries are valid, and leaving it reset-free lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: register decode, TX/RX buffering, sticky
// overflow status and a drain FSM that feeds the transmitter one byte at a time.
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  mem_write,
  input  logic        mem_read,
  output logic        sel,
  output logic [31:0] rdata,
  output logic [7:0]  tx_byte,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]   offset;
  logic         store;
  logic         tx_push;
  logic         stat_wr;
  logic         rx_pop;

  logic         tx_full, tx_empty;
  logic [CW-1:0] tx_count;
  logic [7:0]   tx_head;
  logic         tx_pop;

  logic         rx_full, rx_empty;
  logic [CW-1:0] rx_count;
  logic [7:0]   rx_head;

  logic         tx_overflow, rx_overrun;
  logic         tx_ovf_set, rx_ovr_set;
  logic [4:0]   status;

  drain_state_e state, state_nxt;
  logic [1:0]   wait_cnt, wait_cnt_nxt;
  logic         launch;

  logic         unused_bits;

  // ---------------------------------------------------------------------------
  // Address decode and access strobes
  // ---------------------------------------------------------------------------
  assign sel     = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset  = addr[3:2];
  assign store   = sel & is_store(mem_write);
  assign tx_push = store & (offset == OFF_TX);
  assign stat_wr = store & (offset == OFF_STAT);
  assign rx_pop  = mem_read & sel & (offset == OFF_RX);

  // ---------------------------------------------------------------------------
  // FIFOs
  // ---------------------------------------------------------------------------
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (wdata[7:0]),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .head  (tx_head)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_valid),
    .pop   (rx_pop),
    .din   (rx_byte),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count),
    .head  (rx_head)
  );

  // A full FIFO always has a head, so a same-cycle pop is guaranteed to free
  // a slot; only an unpaired push onto a full FIFO loses data.
  assign tx_ovf_set = tx_push & tx_full & ~tx_pop;
  assign rx_ovr_set = rx_valid & rx_full & ~rx_pop;

  // Sticky error flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_overflow <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      tx_overflow <= tx_ovf_set | (tx_overflow & ~(stat_wr & wdata[ST_TXOVF]));
      rx_overrun  <= rx_ovr_set | (rx_overrun  & ~(stat_wr & wdata[ST_RXOVR]));
    end
  end

  // ---------------------------------------------------------------------------
  // Read data
  // ---------------------------------------------------------------------------
  // Status word assembly from the individual flags.
  always_comb begin
    status             = '0;
    status[ST_TXFULL]  = tx_full;
    status[ST_TXEMPTY] = tx_empty;
    status[ST_RXNE]    = ~rx_empty;
    status[ST_TXOVF]   = tx_overflow;
    status[ST_RXOVR]   = rx_overrun;
  end

  // Register read mux; unselected or reserved addresses read as zero.
  // NOTE: every output of a combinational block gets a default before the case
  // so no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (offset)
        OFF_RX:   rdata = {23'b0, ~rx_empty, (rx_empty ? 8'h00 : rx_head)};
        OFF_STAT: rdata = {27'b0, status};
        default:  rdata = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  // Next-state and launch decision for the transmitter handshake.
  // NOTE: combinational blocks use blocking '=' so later statements see the
  // defaults; the registers below use non-blocking '<=' exclusively.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    launch       = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_empty && !tx_busy) begin
          launch       = 1'b1;
          wait_cnt_nxt = '0;
          state_nxt    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (wait_cnt == 2'(BUSY_TIMEOUT - 1)) begin
          state_nxt = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 2'd1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tx_pop = launch;

  // Drain FSM registers and the registered transmitter interface.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      tx_start <= 1'b0;
      tx_byte  <= 8'h00;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      tx_start <= launch;
      if (launch) tx_byte <= tx_head;
    end
  end

  // Address LSBs, upper store data and occupancy counts are not needed here.
  assign unused_bits = ^{addr[1:0], wdata[31:8], tx_count, rx_count};

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed testbench for uart_mmio_ctrl with a simple transmitter model.
module tb_uart_mmio_ctrl;

  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_RX  = BASE + 32'd4;
  localparam logic [31:0] A_ST  = BASE + 32'd8;
  localparam logic [31:0] A_RSV = BASE + 32'd12;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  mem_write;
  logic        mem_read;
  logic        sel;
  logic [31:0] rdata;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_busy;
  logic [7:0]  rx_byte;
  logic        rx_valid;

  int n_cmp = 0;
  int n_bad = 0;

  // Transmitter model state.
  bit         force_busy = 1'b0;
  bit         model_en   = 1'b0;
  int         busy_len   = 4;
  int         busy_cnt   = 0;
  int         start_cnt  = 0;
  logic [7:0] sent_q[$];

  assign tx_busy = force_busy | (busy_cnt != 0);

  uart_mmio_ctrl #(.BASE_ADDR(BASE), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .addr      (addr),
    .wdata     (wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .sel       (sel),
    .rdata     (rdata),
    .tx_byte   (tx_byte),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter: records each started byte and optionally goes busy.
  always @(negedge clk) begin
    if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    if (tx_start === 1'b1) begin
      sent_q.push_back(tx_byte);
      start_cnt = start_cnt + 1;
      if (model_en) busy_cnt = busy_len;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Bus helpers: called at a falling edge, return at a falling edge.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] mw);
    addr = a; wdata = d; mem_write = mw;
    @(negedge clk);
    mem_write = 2'b00;
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] v);
    addr = a; mem_read = 1'b1;
    #1 v = rdata;
    @(negedge clk);
    mem_read = 1'b0;
  endtask

  task automatic read_status(output logic [31:0] v);
    addr = A_ST; mem_read = 1'b0;
    #1 v = rdata;
  endtask

  task automatic wait_starts(input int base, input int n, input int budget);
    int k = 0;
    while ((start_cnt - base) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if ((start_cnt - base) < n) begin
      n_bad++;
      $display("FAIL start_timeout: got %0d starts want %0d", start_cnt - base, n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0; addr = A_ST; wdata = '0; mem_write = 2'b00; mem_read = 1'b0;
    rx_byte = '0; rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL reset_tx_start: got %0h want 0", tx_start); end
    n_cmp++; if (tx_byte !== 8'h00) begin n_bad++; $display("FAIL reset_tx_byte: got %0h want 00", tx_byte); end
    n_cmp++; if (rdata !== 32'h2) begin n_bad++; $display("FAIL reset_status: got %0h want 2", rdata); end
    n_cmp++; if (sel !== 1'b1) begin n_bad++; $display("FAIL reset_sel: got %0h want 1", sel); end
    rst_n = 1'b1;
    @(negedge clk);
    read_status(v);
    n_cmp++; if (v !== 32'h2) begin n_bad++; $display("FAIL post_reset_status: got %0h want 2", v); end
    addr = A_RX; #1;
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL post_reset_rx: got %0h want 0", rdata); end
  endtask

  task automatic test_tx_drain();
    logic [31:0] v;
    int s0 = start_cnt;
    sent_q.delete(); model_en = 1'b1; busy_len = 10;
    do_store(A_TX, 32'h0000_0041, 2'b11);
    n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL drain_early_start: got %0h want 0", tx_start); end
    @(negedge clk);
    n_cmp++; if (tx_start !== 1'b1) begin n_bad++; $display("FAIL drain_start: got %0h want 1", tx_start); end
    n_cmp++; if (tx_byte !== 8'h41) begin n_bad++; $display("FAIL drain_byte: got %0h want 41", tx_byte); end
    @(negedge clk);
    n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL drain_pulse_width: got %0h want 0", tx_start); end
    repeat (20) @(negedge clk);
    n_cmp++; if (start_cnt - s0 !== 1) begin n_bad++; $display("FAIL drain_count: got %0d want 1", start_cnt - s0); end
    n_cmp++; if (tx_byte !== 8'h41) begin n_bad++; $display("FAIL drain_byte_hold: got %0h want 41", tx_byte); end
    read_status(v);
    n_cmp++; if (v !== 32'h2) begin n_bad++; $display("FAIL drain_status: got %0h want 2", v); end
  endtask

  task automatic test_back_to_back();
    int s0 = start_cnt;
    sent_q.delete(); model_en = 1'b1; busy_len = 2;
    do_store(A_TX, 32'hFFFF_FF5A, 2'b01);
    do_store(A_TX, 32'h0000_1234, 2'b10);
    wait_starts(s0, 2, 50);
    repeat (10) @(negedge clk);
    n_cmp++; if (start_cnt - s0 !== 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", start_cnt - s0); end
    n_cmp++; if (sent_q.size() < 1 || sent_q[0] !== 8'h5A) begin n_bad++; $display("FAIL b2b_byte0: got size %0d want 5a first", sent_q.size()); end
    n_cmp++; if (sent_q.size() < 2 || sent_q[1] !== 8'h34) begin n_bad++; $display("FAIL b2b_byte1: got size %0d want 34 second", sent_q.size()); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] v;
    int s0;
    sent_q.delete(); force_busy = 1'b1;
    repeat (2) @(negedge clk);
    s0 = start_cnt;
    for (int i = 0; i < 9; i++) do_store(A_TX, 32'h10 + i, 2'b11);
    read_status(v);
    n_cmp++; if (v !== 32'h09) begin n_bad++; $display("FAIL ovf_status: got %0h want 9", v); end
    force_busy = 1'b0; busy_len = 3;
    wait_starts(s0, 8, 200);
    repeat (20) @(negedge clk);
    n_cmp++; if (start_cnt - s0 !== 8) begin n_bad++; $display("FAIL ovf_sent_count: got %0d want 8", start_cnt - s0); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (sent_q.size() <= i || sent_q[i] !== 8'(8'h10 + i)) begin
        n_bad++; $display("FAIL ovf_order[%0d]: got size %0d want byte %0h", i, sent_q.size(), 8'h10 + i);
      end
    end
    read_status(v);
    n_cmp++; if (v !== 32'h0A) begin n_bad++; $display("FAIL ovf_sticky: got %0h want a", v); end
    do_store(A_ST, 32'h0000_0008, 2'b11);
    read_status(v);
    n_cmp++; if (v !== 32'h02) begin n_bad++; $display("FAIL ovf_clear: got %0h want 2", v); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] v;
    for (int i = 0; i < 9; i++) begin
      rx_byte = 8'hA0 + 8'(i); rx_valid = 1'b1;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    read_status(v);
    n_cmp++; if (v !== 32'h16) begin n_bad++; $display("FAIL rx_ovr_status: got %0h want 16", v); end
    for (int i = 0; i < 8; i++) begin
      do_load(A_RX, v);
      n_cmp++;
      if (v !== 32'h1A0 + i) begin n_bad++; $display("FAIL rx_read[%0d]: got %0h want %0h", i, v, 32'h1A0 + i); end
    end
    do_load(A_RX, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rx_read_empty: got %0h want 0", v); end
    read_status(v);
    n_cmp++; if (v !== 32'h12) begin n_bad++; $display("FAIL rx_ovr_sticky: got %0h want 12", v); end
    do_store(A_ST, 32'h0000_0010, 2'b11);
    read_status(v);
    n_cmp++; if (v !== 32'h02) begin n_bad++; $display("FAIL rx_ovr_clear: got %0h want 2", v); end
  endtask

  task automatic test_rx_empty_push_pop();
    logic [31:0] v;
    rx_byte = 8'h55; rx_valid = 1'b1; addr = A_RX; mem_read = 1'b1;
    #1 v = rdata;
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rx_pp_first: got %0h want 0", v); end
    @(negedge clk);
    rx_valid = 1'b0; mem_read = 1'b0;
    do_load(A_RX, v);
    n_cmp++; if (v !== 32'h155) begin n_bad++; $display("FAIL rx_pp_second: got %0h want 155", v); end
    do_load(A_RX, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rx_pp_third: got %0h want 0", v); end
  endtask

  task automatic test_busy_timeout();
    int k = 0;
    model_en = 1'b0; sent_q.delete();
    do_store(A_TX, 32'h61, 2'b11);
    do_store(A_TX, 32'h62, 2'b11);
    n_cmp++; if (tx_start !== 1'b1 || tx_byte !== 8'h61) begin n_bad++; $display("FAIL to_first: got start %0h byte %0h want 1/61", tx_start, tx_byte); end
    do begin
      @(negedge clk);
      k++;
    end while (tx_start !== 1'b1 && k < 20);
    n_cmp++; if (k !== 5) begin n_bad++; $display("FAIL to_gap: got %0d cycles want 5", k); end
    n_cmp++; if (tx_byte !== 8'h62) begin n_bad++; $display("FAIL to_second: got %0h want 62", tx_byte); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int s0 = start_cnt;
    model_en = 1'b1; busy_len = 20;
    do_store(A_TX, 32'h77, 2'b11);
    do_store(A_TX, 32'h78, 2'b11);
    do_store(A_TX, 32'h79, 2'b11);
    wait_starts(s0, 1, 20);
    repeat (4) @(negedge clk);
    rst_n = 1'b0; addr = A_ST;
    #1;
    n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL rst_mid_start: got %0h want 0", tx_start); end
    n_cmp++; if (tx_byte !== 8'h00) begin n_bad++; $display("FAIL rst_mid_byte: got %0h want 00", tx_byte); end
    n_cmp++; if (rdata !== 32'h2) begin n_bad++; $display("FAIL rst_mid_status: got %0h want 2", rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    n_cmp++; if (start_cnt - s0 !== 1) begin n_bad++; $display("FAIL rst_mid_flushed: got %0d starts want 1", start_cnt - s0); end
    read_status(v);
    n_cmp++; if (v !== 32'h2) begin n_bad++; $display("FAIL rst_mid_after: got %0h want 2", v); end
  endtask

  task automatic test_decode();
    logic [31:0] v;
    int s0 = start_cnt;
    do_store(A_RSV, 32'h0000_0033, 2'b11);
    read_status(v);
    n_cmp++; if (v !== 32'h2) begin n_bad++; $display("FAIL dec_reserved_write: got %0h want 2", v); end
    do_store(BASE + 32'h10, 32'h0000_0044, 2'b11);
    read_status(v);
    n_cmp++; if (v !== 32'h2) begin n_bad++; $display("FAIL dec_outside_write: got %0h want 2", v); end
    addr = BASE + 32'h10; mem_read = 1'b1; #1;
    n_cmp++; if (sel !== 1'b0 || rdata !== 32'h0) begin n_bad++; $display("FAIL dec_outside_read: got sel %0h rdata %0h want 0/0", sel, rdata); end
    addr = BASE - 32'h4; #1;
    n_cmp++; if (sel !== 1'b0) begin n_bad++; $display("FAIL dec_below: got %0h want 0", sel); end
    addr = A_RSV; #1;
    n_cmp++; if (sel !== 1'b1 || rdata !== 32'h0) begin n_bad++; $display("FAIL dec_reserved_read: got sel %0h rdata %0h want 1/0", sel, rdata); end
    addr = A_TX; #1;
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL dec_txdata_read: got %0h want 0", rdata); end
    mem_read = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (start_cnt - s0 !== 0) begin n_bad++; $display("FAIL dec_no_start: got %0d want 0", start_cnt - s0); end
  endtask

  initial begin
    test_reset();
    test_tx_drain();
    test_back_to_back();
    test_tx_overflow();
    test_rx_overrun();
    test_rx_empty_push_pop();
    test_busy_timeout();
    test_reset_mid();
    test_decode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_mmio_ctrl.md
# uart_mmio_ctrl

Memory-mapped UART controller between the core's data-memory port and the UART TX/RX engines. Decodes a 16-byte register window and buffers transmit bytes in a TX FIFO. A drain FSM feeds the transmitter with a start/busy handshake, and received bytes are buffered in an RX FIFO. The single-cycle core never stalls: overflow conditions drop data and set sticky status bits.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0400, window base; must be 16-byte aligned.
- FIFO_DEPTH, 8, entries per FIFO; power of two, ≥2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  32  data address from the ALU.
- wdata  in  32  store data (RF_OUT2).
- mem_write  in  2  store strobe: 00 none, 01 SB, 10 SH, 11 SW.
- mem_read  in  1  load strobe for the current instruction.
- sel  out  1  combinational; addr is inside the window.
- rdata  out  32  combinational read data.
- tx_byte  out  8  byte presented to the transmitter.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_busy  in  1  transmitter is shifting.
- rx_byte  in  8  received byte.
- rx_valid  in  1  one-cycle pulse; rx_byte is valid.

## Operation
- **Decode:** sel = (addr[31:4] == BASE_ADDR[31:4]). Offset addr[3:2] selects:
  - 0 TX_DATA
  - 1 RX_DATA
  - 2 STATUS
  - 3 reserved: reads 0, writes ignored.
- **TX_DATA write:** any mem_write≠00 pushes wdata[7:0] into the TX FIFO. If the FIFO is full, the byte is dropped and tx_overflow is set. A read of TX_DATA returns 0.
- **RX_DATA read:** rdata = {23'b0, rx_nonempty, head}. If the FIFO is empty, head reads as 8'h00. A pop occurs at the edge only when mem_read & sel & offset==1 & nonempty.
- **STATUS read:** rdata = {27'b0, rx_overrun, tx_overflow, rx_nonempty, tx_empty, tx_full}.
- **STATUS write:** wdata[3]=1 clears tx_overflow; wdata[4]=1 clears rx_overrun. If set and clear occur in the same cycle, set wins.
- **RX push:** rx_valid pushes rx_byte. If the FIFO is full (after any same-cycle pop), the byte is dropped and rx_overrun is set.
- **rdata when not selected:** rdata=0 when sel=0.
- **Drain FSM states:**
  - IDLE: if TX count>0 & !tx_busy, register tx_byte=head, pulse tx_start, pop, go to WAIT_BUSY.
  - WAIT_BUSY: on tx_busy=1 go to WAIT_DONE. If tx_busy has not risen after 4 cycles, return to IDLE; the byte is considered sent.
  - WAIT_DONE: on tx_busy=0 go to IDLE.
- **Simultaneous push and pop:**
  - On a full FIFO, both occur; the pop frees the slot and the push is accepted.
  - On an empty FIFO, the push is accepted, the pop is ignored, and rdata shows empty.
- **Pointers:** FIFO pointers are log2(FIFO_DEPTH)+1 bits. Full/empty are derived from the MSB comparison, and wrap-around is natural.

## Timing
- **Reset (async assert, sync release):**
  - FIFOs empty; FSM IDLE; tx_start=0, tx_byte=0; sticky bits 0.
  - Combinational outputs after reset: STATUS reads 0x2, sel/rdata follow inputs.
- **Store-to-FIFO:** the byte is visible in count the next cycle. Earliest tx_start is 1 cycle after the push edge, i.e. a 2-cycle store-to-start latency.
- **tx_start:** exactly one cycle high per byte; tx_byte is held stable until the next start.
- **Per-byte overhead:** the minimum byte period is busy-duration + 2 cycles.
- **RX pop:** the pop takes effect at the load's edge; the next load sees the next entry.
- **Reset mid-transfer:** all FIFO contents are lost and tx_start deasserts immediately. The transmitter is not aborted; that is its own concern.

## Structure
- Package uart_mmio_pkg:
  - Offset constants OFF_TX=2'd0, OFF_RX=2'd1, OFF_STAT=2'd2.
  - Status bit indices ST_TXFULL..ST_RXOVR.
  - MemWrite encodings.
  - Drain FSM state enum {IDLE, WAIT_BUSY, WAIT_DONE}.
- Sub-module sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count/head), instantiated twice (TX and RX).

## Test plan
- **TX drain:** SW 0x41 to BASE+0, tx_busy high 10 cycles after start → tx_start pulses once with tx_byte=0x41 two cycles after the store; STATUS=0x2 afterwards.
- **TX overflow:** hold tx_busy=1 and store 9 bytes (0x10..0x18) with depth 8 → 0x18 is dropped, STATUS bit3=1 and bit0=1. Release busy → bytes 0x10..0x17 are sent in order. Store STATUS wdata=0x8 → bit3 clears.
- **RX overrun and read-back:** 9 rx_valid pulses 0xA0..0xA8 → rx_overrun=1. Eight loads of BASE+4 return 0x1A0..0x1A7; the ninth returns 0x000.
- **RX empty push+pop:** rx_valid(0x55) in the same cycle as an RX_DATA load on an empty FIFO → load returns 0x000; the next load returns 0x155.
- **Busy timeout and reset:** tx_busy never rises → FSM returns to IDLE 4 cycles after tx_start and the next byte starts. Assert reset mid-WAIT_DONE → tx_start=0, FIFOs empty, STATUS=0x2.
- **Decode:** a store to BASE+0xC or to BASE+0x10 → no FIFO change; sel=0 for BASE+0x10.
